// File: rtl/onc_16_mem_arb_pkg.sv
// onc_16_mem_arb_pkg: shared widths, read-owner codes and arbiter state encoding
package onc_16_mem_arb_pkg;
  localparam int ADDR_W = 16;
  localparam int DATA_W = 16;
  typedef enum logic [1:0] {OWN_NONE, OWN_D, OWN_I, OWN_X} own_e;
  typedef enum logic {ST_NORMAL, ST_LOCKED} state_e;
endpackage

// File: rtl/onc_16_mem_arb_if.sv
// onc_16_mem_arb_if: D/I/X requester ports, core stall and SRAM port; slave = arbiter, master = core/loader/SRAM side
import onc_16_mem_arb_pkg::*;
interface onc_16_mem_arb_if;
  logic d_req, d_we, d_gnt, d_rvalid;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata, d_rdata;
  logic i_req, i_gnt, i_rvalid;
  logic [ADDR_W-1:0] i_addr;
  logic [DATA_W-1:0] i_rdata;
  logic x_req, x_we, x_lock, x_gnt, x_rvalid;
  logic [ADDR_W-1:0] x_addr;
  logic [DATA_W-1:0] x_wdata, x_rdata;
  logic cpu_stall, mem_en, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;
  modport slave (
    input d_req, d_we, d_addr, d_wdata, i_req, i_addr, x_req, x_we, x_addr, x_wdata, x_lock, mem_rdata,
    output d_gnt, d_rvalid, d_rdata, i_gnt, i_rvalid, i_rdata, x_gnt, x_rvalid, x_rdata,
    output cpu_stall, mem_en, mem_we, mem_addr, mem_wdata
  );
  modport master (
    output d_req, d_we, d_addr, d_wdata, i_req, i_addr, x_req, x_we, x_addr, x_wdata, x_lock, mem_rdata,
    input d_gnt, d_rvalid, d_rdata, i_gnt, i_rvalid, i_rdata, x_gnt, x_rvalid, x_rdata,
    input cpu_stall, mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/onc_16_mem_arb_prio.sv
// onc_16_arb_prio: one-hot grant {x,i,d}; D>I>X normally, X first when boosted, X only when locked
module onc_16_arb_prio (
  input  logic       d_req,
  input  logic       i_req,
  input  logic       x_req,
  input  logic       boost,
  input  logic       locked,
  output logic [2:0] gnt
);
  always_comb gnt = locked ? {x_req, 2'b00} : (boost && x_req) ? 3'b100 : d_req ? 3'b001 : i_req ? 3'b010 : {x_req, 2'b00};
endmodule

// File: rtl/onc_16_mem_arb.sv
// onc_16_mem_arb: 3-way SRAM arbiter (ports: clock, rst, bus = D/I/X requesters, cpu_stall, SRAM) with X starvation boost and X lock
import onc_16_mem_arb_pkg::*;
module onc_16_mem_arb #(
  parameter int STARVE_MAX = 8
) (
  input logic               clock,
  input logic               rst,
  onc_16_mem_arb_if.slave   bus
);
  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  logic [2:0] gnt;
  logic [CNT_W-1:0] starve_q, starve_d;
  state_e state_q, state_d;
  own_e rd_owner_q, rd_owner_d;
  logic boost;
  assign boost = starve_q == CNT_W'(STARVE_MAX);
  onc_16_arb_prio u_prio (
    .d_req  (bus.d_req),
    .i_req  (bus.i_req),
    .x_req  (bus.x_req),
    .boost  (boost),
    .locked (state_q == ST_LOCKED),
    .gnt    (gnt)
  );
  always_comb begin
    bus.d_gnt     = gnt[0];
    bus.i_gnt     = gnt[1];
    bus.x_gnt     = gnt[2];
    bus.mem_en    = |gnt;
    bus.mem_we    = (gnt[0] && bus.d_we) || (gnt[2] && bus.x_we);
    bus.mem_addr  = gnt[0] ? bus.d_addr : gnt[1] ? bus.i_addr : bus.x_addr;
    bus.mem_wdata = gnt[0] ? bus.d_wdata : bus.x_wdata;
    bus.cpu_stall = (bus.d_req && !gnt[0]) || (bus.i_req && !gnt[1]) || state_q == ST_LOCKED;
    bus.d_rvalid  = rd_owner_q == OWN_D;
    bus.i_rvalid  = rd_owner_q == OWN_I;
    bus.x_rvalid  = rd_owner_q == OWN_X;
    bus.d_rdata   = bus.mem_rdata;
    bus.i_rdata   = bus.mem_rdata;
    bus.x_rdata   = bus.mem_rdata;
    starve_d      = (gnt[2] || !bus.x_req) ? '0 : boost ? starve_q : starve_q + 1'b1;
    state_d       = gnt[2] ? (bus.x_lock ? ST_LOCKED : ST_NORMAL) : state_q;
    rd_owner_d    = (gnt[0] && !bus.d_we) ? OWN_D : gnt[1] ? OWN_I : (gnt[2] && !bus.x_we) ? OWN_X : OWN_NONE;
  end
  always_ff @(posedge clock) begin
    if (rst) begin
      starve_q   <= '0;
      state_q    <= ST_NORMAL;
      rd_owner_q <= OWN_NONE;
    end else begin
      starve_q   <= starve_d;
      state_q    <= state_d;
      rd_owner_q <= rd_owner_d;
    end
  end
endmodule

// File: tb/tb_onc_16_mem_arb.sv
// tb_onc_16_mem_arb: directed scoreboard bench for onc_16_mem_arb with a behavioural 1-cycle SRAM
import onc_16_mem_arb_pkg::*;
module tb_onc_16_mem_arb;
  typedef struct {own_e own; logic [15:0] data;} exp_t;
  logic clock = 1'b0;
  logic rst;
  int n_cmp = 0, n_err = 0;
  exp_t q[$];
  logic [15:0] sram [0:1023];
  logic [15:0] rd_q;
  onc_16_mem_arb_if bus ();
  onc_16_mem_arb #(.STARVE_MAX(8)) dut (.clock(clock), .rst(rst), .bus(bus));
  always #5 clock = ~clock;
  always @(posedge clock) if (bus.mem_en) begin
    if (bus.mem_we) sram[bus.mem_addr[9:0]] <= bus.mem_wdata;
    rd_q <= sram[bus.mem_addr[9:0]];
  end
  assign bus.mem_rdata = rd_q;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic push(input own_e own, input logic [15:0] data);
    exp_t e;
    e.own = own;
    e.data = data;
    q.push_back(e);
  endtask
  task automatic step();
    exp_t e;
    @(posedge clock);
    #1;
    if (q.size() != 0) begin
      e = q.pop_front();
      chk("rvalid_d", bus.d_rvalid, e.own == OWN_D);
      chk("rvalid_i", bus.i_rvalid, e.own == OWN_I);
      chk("rvalid_x", bus.x_rvalid, e.own == OWN_X);
      chk("rdata", e.own == OWN_D ? bus.d_rdata : e.own == OWN_I ? bus.i_rdata : bus.x_rdata, e.data);
    end else
      chk("no_rvalid", {bus.d_rvalid, bus.i_rvalid, bus.x_rvalid}, 0);
  endtask
  task automatic xw(input logic [15:0] a, input logic [15:0] d, input logic lk);
    bus.x_req = 1; bus.x_we = 1; bus.x_addr = a; bus.x_wdata = d; bus.x_lock = lk;
    #1;
    chk("xw_gnt", bus.x_gnt, 1);
    chk("xw_mem_we", bus.mem_we, 1);
    step();
    bus.x_req = 0; bus.x_lock = 0;
  endtask
  initial begin
    rst = 1;
    bus.d_req = 0; bus.d_we = 0; bus.d_addr = 0; bus.d_wdata = 0;
    bus.i_req = 0; bus.i_addr = 0;
    bus.x_req = 0; bus.x_we = 0; bus.x_addr = 0; bus.x_wdata = 0; bus.x_lock = 0;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_gnt", {bus.d_gnt, bus.i_gnt, bus.x_gnt, bus.mem_en, bus.mem_we, bus.cpu_stall}, 0);
    chk("rst_rvalid", {bus.d_rvalid, bus.i_rvalid, bus.x_rvalid}, 0);
    chk("rst_state", dut.state_q, ST_NORMAL);
    chk("rst_starve", dut.starve_q, 0);
    rst = 0;
    xw(16'h0010, 16'hBEEF, 0);
    xw(16'h0004, 16'h4444, 0);
    xw(16'h0100, 16'h1111, 0);
    xw(16'h0101, 16'h2222, 0);
    bus.d_req = 1; bus.d_we = 0; bus.d_addr = 16'h0010;
    #1;
    chk("t1_gnt", {bus.d_gnt, bus.i_gnt, bus.x_gnt}, 3'b100);
    chk("t1_mem", {bus.mem_en, bus.mem_we, bus.cpu_stall}, 3'b100);
    chk("t1_addr", bus.mem_addr, 16'h0010);
    push(OWN_D, 16'hBEEF);
    step();
    bus.d_req = 1; bus.d_we = 1; bus.d_addr = 16'h0020; bus.d_wdata = 16'hA5A5;
    bus.i_req = 1; bus.i_addr = 16'h0004;
    #1;
    chk("t2_gnt", {bus.d_gnt, bus.i_gnt, bus.x_gnt}, 3'b100);
    chk("t2_stall", bus.cpu_stall, 1);
    chk("t2_we", bus.mem_we, 1);
    chk("t2_addr", bus.mem_addr, 16'h0020);
    step();
    bus.d_req = 0; bus.d_we = 0;
    #1;
    chk("t2_i_gnt", {bus.d_gnt, bus.i_gnt, bus.cpu_stall}, 3'b010);
    chk("t2_i_addr", bus.mem_addr, 16'h0004);
    push(OWN_I, 16'h4444);
    step();
    bus.i_req = 0;
    bus.d_req = 1; bus.d_addr = 16'h0020;
    #1;
    push(OWN_D, 16'hA5A5);
    step();
    bus.d_addr = 16'h0010; bus.i_req = 1; bus.i_addr = 16'h0004;
    bus.x_req = 1; bus.x_we = 0; bus.x_addr = 16'h0100;
    for (int c = 1; c <= 8; c++) begin
      #1;
      chk("t3_d_gnt", {bus.d_gnt, bus.x_gnt}, 2'b10);
      chk("t3_starve", dut.starve_q, c - 1);
      push(OWN_D, 16'hBEEF);
      step();
    end
    #1;
    chk("t3_x_gnt", {bus.d_gnt, bus.i_gnt, bus.x_gnt}, 3'b001);
    chk("t3_starve_max", dut.starve_q, 8);
    chk("t3_stall", bus.cpu_stall, 1);
    push(OWN_X, 16'h1111);
    step();
    chk("t3_starve_clr", dut.starve_q, 0);
    chk("t3_d_again", bus.d_gnt, 1);
    push(OWN_D, 16'hBEEF);
    step();
    bus.d_req = 0; bus.i_req = 0; bus.x_req = 0;
    #1;
    step();
    for (int k = 0; k < 4; k++) begin
      bus.i_req = k > 0; bus.i_addr = 16'h0101;
      bus.x_req = 1; bus.x_we = 1; bus.x_addr = 16'(k); bus.x_wdata = 16'hC000 + 16'(k); bus.x_lock = k < 3;
      #1;
      chk("t4_x_gnt", bus.x_gnt, 1);
      if (k > 0) chk("t4_locked", {bus.i_gnt, bus.cpu_stall}, 2'b01);
      step();
    end
    bus.x_req = 0; bus.x_lock = 0;
    #1;
    chk("t4_i_gnt", {bus.i_gnt, bus.cpu_stall}, 2'b10);
    chk("t4_state", dut.state_q, ST_NORMAL);
    push(OWN_I, 16'h2222);
    step();
    bus.i_req = 0;
    bus.x_req = 1; bus.x_we = 0; bus.x_addr = 16'h0002;
    #1;
    push(OWN_X, 16'hC002);
    step();
    bus.x_req = 0;
    xw(16'h0030, 16'h7777, 1);
    bus.d_req = 1; bus.d_we = 0; bus.d_addr = 16'h0010;
    #1;
    chk("t5_locked", {bus.d_gnt, bus.cpu_stall}, 2'b01);
    rst = 1;
    step();
    chk("t5_state", dut.state_q, ST_NORMAL);
    chk("t5_rst_gnt", bus.d_gnt, 1);
    step();
    chk("t5_dropped", bus.d_rvalid, 0);
    chk("t5_starve", dut.starve_q, 0);
    rst = 0;
    #1;
    push(OWN_D, 16'hBEEF);
    step();
    bus.d_req = 0;
    for (int k = 0; k < 8; k++) begin
      bus.i_req = 1; bus.i_addr = 16'h0100 + 16'(k & 1);
      #1;
      chk("t6_i_gnt", bus.i_gnt, 1);
      push(OWN_I, (k & 1) != 0 ? 16'h2222 : 16'h1111);
      step();
    end
    bus.i_req = 0;
    #1;
    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
